spi_target: RTL

SPI mode-0 responder (target) that lets an external SPI controller read and write a small bank of 8-bit configuration registers through the user IO pins. It is the far end of the SPI link driven by `spi_wrapper`, and sits beside it inside the user project. It oversamples SCK/CSB/MOSI on `wb_clk_i`, decodes a command byte plus data bytes, and drives MISO with output-enable control matching the `io_oeb` convention.

---
 rtl/spi_target.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target giving an external controller read/write access to NUM_REGS 8-bit registers.
// Latency: SYNC_STAGES+1 wb_clk_i cycles from a pad SCK edge to the internal action (write, strobe, MISO update).
// Backpressure: none; the controller paces the link and wb_clk_i must run at least 4x SCK.
// Optional feature: define SPI_TARGET_AUTOINC_EN for burst access with address auto-increment.
module spi_target #(
   parameter int NUM_REGS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         sck_i,
   input  logic                         csb_i,
   input  logic                         mosi_i,
   output logic                         miso_o,
   output logic                         miso_oeb_o,
   output logic [8*NUM_REGS-1:0]        regs_o,
   output logic                         wr_stb_o,
   output logic [$clog2(NUM_REGS)-1:0]  wr_addr_o,
   output logic                         frame_err_o
);

   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_csb_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_prev;
   logic                   r_csb_prev;
   logic                   r_armed;
   logic [2:0]             r_bitcnt;
   logic [6:0]             r_shift;
   logic [7:0]             r_tx;
   logic                   r_wr;
   logic [6:0]             r_addr;
   logic [7:0]             r_regs [NUM_REGS];
   logic                   r_wr_stb;
   logic [AW-1:0]          r_wr_addr;
   logic                   r_frame_err;

   logic          w_sck, w_csb, w_mosi;
   logic          w_sck_rise, w_sck_fall, w_cs_act, w_cs_end;
   logic          w_in_frame, w_shift_rise, w_byte_done;
   logic [7:0]    w_byte;
   logic          w_cmd_ok, w_addr_ok;
   logic [AW-1:0] w_cmd_idx, w_idx;

   assign w_sck        = r_sck_sync[SYNC_STAGES-1];
   assign w_csb        = r_csb_sync[SYNC_STAGES-1];
   assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
   assign w_sck_rise   = w_sck & ~r_sck_prev;
   assign w_sck_fall   = ~w_sck & r_sck_prev;
   assign w_cs_act     = ~w_csb;
   assign w_cs_end     = w_csb & ~r_csb_prev;
   assign w_in_frame   = (r_state != S_IDLE);
   assign w_shift_rise = w_sck_rise & w_in_frame;
   assign w_byte       = {r_shift, w_mosi};
   assign w_byte_done  = w_shift_rise && (r_bitcnt == 3'd7);
   // Any address bit at or above AW set makes the access invalid.
   assign w_cmd_ok     = ((w_byte[6:0] >> AW) == 7'd0);
   assign w_addr_ok    = ((r_addr >> AW) == 7'd0);
   assign w_cmd_idx    = w_byte[AW-1:0];
   assign w_idx        = r_addr[AW-1:0];

`ifdef SPI_TARGET_AUTOINC_EN
   logic [AW-1:0] w_idx_inc;
   assign w_idx_inc = w_idx + AW'(1);
`endif

   // Pad synchronizers and edge history. CSB resets to "selected" so a frame
   // already in progress at reset release shows no edge; r_armed waits for CSB high.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_sck_sync  <= '0;
         r_csb_sync  <= '0;
         r_mosi_sync <= '0;
         r_sck_prev  <= 1'b0;
         r_csb_prev  <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
         r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
         r_sck_prev  <= w_sck;
         r_csb_prev  <= w_csb;
         if (w_csb) r_armed <= 1'b1;
      end
   end

   // Frame state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode; end of chip-select always wins, after the byte in flight completes.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_cs_act && r_armed) w_state_nxt = S_CMD;
         S_CMD:  if (w_byte_done) w_state_nxt = S_DATA;
`ifdef SPI_TARGET_AUTOINC_EN
         S_DATA: if (w_byte_done) w_state_nxt = S_DATA;
`else
         S_DATA: if (w_byte_done) w_state_nxt = S_DONE;
`endif
         default: w_state_nxt = r_state;
      endcase
      if (w_cs_end) w_state_nxt = S_IDLE;
   end

   // Shifting, command latch, register writes, MISO shifter and status pulses.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_bitcnt    <= 3'd0;
         r_shift     <= 7'd0;
         r_tx        <= 8'h00;
         r_wr        <= 1'b0;
         r_addr      <= 7'd0;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= '0;
         r_frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
      end else begin
         r_wr_stb    <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_shift_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         // Bit 7 is presented at byte start, so the fall that precedes the first
         // rise of a byte (counter still 0) must not shift.
         if (r_state == S_DATA && !r_wr && w_sck_fall && r_bitcnt != 3'd0)
            r_tx <= {r_tx[6:0], 1'b0};
         if (w_byte_done && r_state == S_CMD) begin
            r_wr   <= w_byte[7];
            r_addr <= w_byte[6:0];
            r_tx   <= w_cmd_ok ? r_regs[w_cmd_idx] : 8'h00;
         end
         if (w_byte_done && r_state == S_DATA) begin
            if (r_wr && w_addr_ok) begin
               r_regs[w_idx] <= w_byte;
               r_wr_stb      <= 1'b1;
               r_wr_addr     <= w_idx;
            end
`ifdef SPI_TARGET_AUTOINC_EN
            r_addr[AW-1:0] <= w_idx_inc;
            r_tx           <= w_addr_ok ? r_regs[w_idx_inc] : 8'h00;
`endif
         end
         if (w_cs_end) begin
            r_bitcnt    <= 3'd0;
            r_frame_err <= w_in_frame && (r_bitcnt != 3'd0) && !w_byte_done;
         end
      end
   end

   genvar g;
   for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[8*g +: 8] = r_regs[g];
   end

   assign miso_oeb_o  = !(r_state == S_DATA && !r_wr);
   assign miso_o      = miso_oeb_o ? 1'b0 : r_tx[7];
   assign wr_stb_o    = r_wr_stb;
   assign wr_addr_o   = r_wr_addr;
   assign frame_err_o = r_frame_err;

endmodule
